log_dump_reader: RTL and testbench

//  Read-out side of the BRAM capture logger. Once the logger reports full, it sweeps log addresses 0..RAM_DEPTH-1.

---
 rtl/log_dump_reader_pkg.sv | 33 +++
 rtl/log_dump_reader_word_serializer.sv | 46 ++++
 rtl/log_dump_reader.sv | 118 +++++++++++
 tb/tb_log_dump_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_dump_reader_pkg.sv
// Shared definitions for the log dump reader: FSM states and sizing helpers.
package log_dump_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Number of bits needed to represent value (0 -> 0, 1 -> 1, 1023 -> 10).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Bytes per log word once zero-extended to a byte multiple.
  function automatic int num_bytes(input int width);
    return (width + 7) / 8;
  endfunction

  localparam int DEF_RAM_WIDTH = 18;
  localparam int DEF_NB        = num_bytes(DEF_RAM_WIDTH);

endpackage

// File: rtl/log_dump_reader_word_serializer.sv
// Holds one zero-extended log word and hands it out MSB byte first over valid/ready.
module log_dump_reader_word_serializer
  import log_dump_reader_pkg::*;
#(
  parameter int NB = DEF_NB
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [8*NB-1:0] i_word,
  input  logic            i_ready,
  output logic [7:0]      o_byte,
  output logic            o_valid,
  output logic            o_last_acc
);

  localparam int WORD_W = 8 * NB;
  localparam int IDX_W  = (NB > 1) ? clogb2(NB - 1) : 1;

  logic [WORD_W-1:0] r_sh;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;

  // Load a fresh word, then shift one byte out per accepted handshake; the
  // shifted-in zeros leave o_byte at 0 once the word is exhausted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh    <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_sh    <= i_word;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_sh <= r_sh << 8;
      if (r_idx == IDX_W'(NB - 1)) r_valid <= 1'b0;
      else                         r_idx   <= r_idx + 1'b1;
    end
  end

  assign o_byte     = r_sh[WORD_W-1 -: 8];
  assign o_valid    = r_valid;
  assign o_last_acc = r_valid && i_ready && (r_idx == IDX_W'(NB - 1));

endmodule

// File: rtl/log_dump_reader.sv
// Sweeps the full capture log once the logger is full and streams every word
// out as bytes (MSB first) on a valid/ready byte interface.
module log_dump_reader
  import log_dump_reader_pkg::*;
#(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_start_dump,
  input  logic                              i_mem_full,
  output logic                              o_read_log,
  output logic [clogb2(RAM_DEPTH-1)-1:0]    o_addr_log_to_mem,
  input  logic [RAM_WIDTH-1:0]              i_data_log_from_mem,
  output logic [7:0]                        o_byte,
  output logic                              o_byte_valid,
  input  logic                              i_byte_ready,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int ADDR_W = clogb2(RAM_DEPTH - 1);
  localparam int NB     = num_bytes(RAM_WIDTH);
  localparam int WORD_W = 8 * NB;
  localparam int LAT_W  = clogb2(READ_LATENCY);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LAT_W-1:0]  r_lat;
  logic              r_read;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_last_acc;
  logic [WORD_W-1:0] w_word;

  // The read data is valid in the last WAIT cycle; capture it on that edge.
  assign w_load = (r_state == S_WAIT) && (r_lat == LAT_W'(READ_LATENCY - 1));
  assign w_word = WORD_W'(i_data_log_from_mem);

  log_dump_reader_word_serializer #(.NB(NB)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_word     (w_word),
    .i_ready    (i_byte_ready),
    .o_byte     (o_byte),
    .o_valid    (o_byte_valid),
    .o_last_acc (w_last_acc)
  );

  // Dump sequencer: read a word, wait out the BRAM latency, drain it, advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_lat   <= '0;
      r_read  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start_dump && i_mem_full) begin
            r_state <= S_READ;
            r_addr  <= '0;
            r_read  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
          r_lat   <= '0;
        end
        S_WAIT: begin
          if (w_load) begin
            r_state <= S_SEND;
            r_read  <= 1'b0;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_SEND: begin
          if (w_last_acc) begin
            if (r_addr == ADDR_W'(RAM_DEPTH - 1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_addr  <= r_addr + 1'b1;
              r_read  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_read_log        = r_read;
  assign o_addr_log_to_mem = r_addr;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule

// File: tb/tb_log_dump_reader.sv
// Bench for log_dump_reader: BRAM image preloaded with 0..1023 (as the logger
// leaves it), byte stream compared against the word/byte rule computed here.
module tb_log_dump_reader;

  localparam int D  = 1024;
  localparam int NB = 3;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0, full = 1'b0, ready = 1'b1, aux_start = 1'b0;
  logic        rd, bv, busy, done;
  logic [9:0]  addr;
  logic [17:0] data;
  logic [7:0]  byt;
  logic        rd1, bv1, busy1, done1, rd3, bv3, busy3, done3;
  logic [9:0]  addr1, addr3;
  logic [17:0] data1, data3;
  logic [7:0]  byt1, byt3;

  logic [17:0] mem [D];
  logic [17:0] p2 [2];
  logic [17:0] p1 [1];
  logic [17:0] p3 [3];

  // BRAM models: data appears READ_LATENCY edges after the read; junk when not read
  always @(posedge clk) begin
    p2[0] <= rd ? mem[addr] : 18'($urandom);
    p2[1] <= p2[0];
    p1[0] <= rd1 ? mem[addr1] : 18'($urandom);
    p3[0] <= rd3 ? mem[addr3] : 18'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign data  = p2[RL-1];
  assign data1 = p1[0];
  assign data3 = p3[2];

  log_dump_reader #(.RAM_WIDTH(18), .RAM_DEPTH(D), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .i_start_dump(start), .i_mem_full(full),
    .o_read_log(rd), .o_addr_log_to_mem(addr), .i_data_log_from_mem(data),
    .o_byte(byt), .o_byte_valid(bv), .i_byte_ready(ready), .o_busy(busy), .o_done(done));

  log_dump_reader #(.RAM_WIDTH(18), .RAM_DEPTH(D), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .i_start_dump(aux_start), .i_mem_full(1'b1),
    .o_read_log(rd1), .o_addr_log_to_mem(addr1), .i_data_log_from_mem(data1),
    .o_byte(byt1), .o_byte_valid(bv1), .i_byte_ready(1'b1), .o_busy(busy1), .o_done(done1));

  log_dump_reader #(.RAM_WIDTH(18), .RAM_DEPTH(D), .READ_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .i_start_dump(aux_start), .i_mem_full(1'b1),
    .o_read_log(rd3), .o_addr_log_to_mem(addr3), .i_data_log_from_mem(data3),
    .o_byte(byt3), .o_byte_valid(bv3), .i_byte_ready(1'b1), .o_busy(busy3), .o_done(done3));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, mode = 0;
  logic [7:0] got_q [$];
  int done_cnt, done_cyc, rd_cyc, stab_err, n_stall, rd_addr0;
  logic hold;
  logic [7:0] hold_byte;
  int a1_cnt, a1_err, a1_rd, a1_done, a3_cnt, a3_err, a3_rd, a3_done;

  // Expected n-th byte of a dump: word n/NB zero-extended, bytes MSB first.
  function automatic logic [7:0] exp_byte(input int n);
    logic [23:0] w;
    w = 24'(mem[n / NB]);
    return 8'(w >> (8 * (NB - 1 - (n % NB))));
  endfunction

  function automatic int stream_errs();
    int e = 0;
    for (int n = 0; n < got_q.size() && n < D * NB; n++)
      if (got_q[n] !== exp_byte(n)) e++;
    return e;
  endfunction

  task automatic clear_rec();
    got_q.delete();
    done_cnt = 0; done_cyc = -1; rd_cyc = -1; rd_addr0 = -1;
    stab_err = 0; n_stall = 0; hold = 1'b0; hold_byte = 8'h00;
    a1_cnt = 0; a1_err = 0; a1_rd = -1; a1_done = -1;
    a3_cnt = 0; a3_err = 0; a3_rd = -1; a3_done = -1;
  endtask

  // One clock: drive ready for the coming edge, then observe what that edge will see.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       ready = 1'b1;
      1:       ready = ($urandom_range(0, 9) < 3);
      default: ready = 1'b0;
    endcase
    if (hold && (!bv || byt !== hold_byte)) stab_err++;
    hold      = bv && !ready;
    hold_byte = byt;
    if (hold) n_stall++;
    if (bv && ready) got_q.push_back(byt);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rd && rd_cyc < 0) begin rd_cyc = cyc; rd_addr0 = int'(addr); end
    if (bv1) begin
      if (a1_cnt >= D * NB || byt1 !== exp_byte(a1_cnt)) a1_err++;
      a1_cnt++;
    end
    if (bv3) begin
      if (a3_cnt >= D * NB || byt3 !== exp_byte(a3_cnt)) a3_err++;
      a3_cnt++;
    end
    if (rd1 && a1_rd < 0) a1_rd = cyc;
    if (rd3 && a3_rd < 0) a3_rd = cyc;
    if (done1) a1_done = cyc;
    if (done3) a3_done = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_dump(input int m, output logic timed_out);
    mode = m;
    full = 1'b1;
    pulse_start();
    for (int i = 0; i < 40000 && done_cyc < 0; i++) tick();
    timed_out = (done_cyc < 0);
    mode = 0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_rec();
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if ({busy, done, rd, bv} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, rd, bv}); end
    n_cmp++; if (addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", addr); end
    n_cmp++; if (byt !== 8'h00) begin n_bad++; $display("FAIL reset_byte got %h want 00", byt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_dump();
    logic to;
    clear_rec();
    run_dump(0, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL full_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != D * NB) begin n_bad++; $display("FAIL full_count got %0d want %0d", got_q.size(), D * NB); end
    n_cmp++; if (stream_errs() != 0) begin n_bad++; $display("FAIL full_stream got %0d bad bytes want 0", stream_errs()); end
    if (got_q.size() == D * NB) begin
      n_cmp++; if ({got_q[93], got_q[94], got_q[95]} !== 24'h00001F) begin n_bad++; $display("FAIL full_word31 got %h want 00001f", {got_q[93], got_q[94], got_q[95]}); end
      n_cmp++; if ({got_q[3069], got_q[3070], got_q[3071]} !== 24'h0003FF) begin n_bad++; $display("FAIL full_word1023 got %h want 0003ff", {got_q[3069], got_q[3070], got_q[3071]}); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL full_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_after got %b want 0", busy); end
    n_cmp++; if (done_cyc - rd_cyc != D * (1 + RL + NB)) begin n_bad++; $display("FAIL full_cycles got %0d want %0d", done_cyc - rd_cyc, D * (1 + RL + NB)); end
  endtask

  task automatic test_random_ready();
    logic to;
    clear_rec();
    run_dump(1, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rand_timeout got timeout want done"); end
    n_cmp++; if (got_q.size() != D * NB) begin n_bad++; $display("FAIL rand_count got %0d want %0d", got_q.size(), D * NB); end
    n_cmp++; if (stream_errs() != 0) begin n_bad++; $display("FAIL rand_stream got %0d bad bytes want 0", stream_errs()); end
    n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL rand_stable got %0d unstable cycles want 0", stab_err); end
    n_cmp++; if (n_stall == 0) begin n_bad++; $display("FAIL rand_stalls got 0 stalled cycles want >0"); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL rand_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_no_full();
    logic saw_busy, saw_rd;
    clear_rec();
    full = 1'b0;
    saw_busy = 1'b0; saw_rd = 1'b0;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      tick();
      saw_busy |= busy;
      saw_rd   |= rd;
    end
    n_cmp++; if (saw_busy) begin n_bad++; $display("FAIL nofull_busy got 1 want 0"); end
    n_cmp++; if (saw_rd) begin n_bad++; $display("FAIL nofull_read got 1 want 0"); end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL nofull_bytes got %0d want 0", got_q.size()); end
  endtask

  task automatic test_restart_ignored();
    logic reached;
    clear_rec();
    mode = 0;
    full = 1'b1;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 10000 && !reached; i++) begin
      tick();
      reached = busy && (addr == 10'd300);
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL restart_reach300 got timeout want addr 300"); end
    pulse_start();
    full = 1'b0;
    for (int i = 0; i < 10000 && done_cyc < 0; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (got_q.size() != D * NB) begin n_bad++; $display("FAIL restart_count got %0d want %0d", got_q.size(), D * NB); end
    n_cmp++; if (stream_errs() != 0) begin n_bad++; $display("FAIL restart_stream got %0d bad bytes want 0", stream_errs()); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc - rd_cyc != D * (1 + RL + NB)) begin n_bad++; $display("FAIL restart_cycles got %0d want %0d", done_cyc - rd_cyc, D * (1 + RL + NB)); end
  endtask

  task automatic test_reset_mid();
    logic reached, to;
    clear_rec();
    mode = 0;
    full = 1'b1;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 10000 && !reached; i++) begin
      tick();
      reached = bv && (addr == 10'd500);
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL rstmid_reach500 got timeout want send at 500"); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if ({busy, done, rd, bv} !== 4'b0) begin n_bad++; $display("FAIL rstmid_ctrl got %b want 0000", {busy, done, rd, bv}); end
    n_cmp++; if ({addr, byt} !== 18'd0) begin n_bad++; $display("FAIL rstmid_addr_byte got %h/%h want 0/0", addr, byt); end
    tick();
    tick();
    reset = 1'b0;
    clear_rec();
    run_dump(0, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rstmid_timeout got timeout want done"); end
    n_cmp++; if (rd_addr0 != 0) begin n_bad++; $display("FAIL rstmid_first_addr got %0d want 0", rd_addr0); end
    if (got_q.size() >= 6) begin
      n_cmp++; if ({got_q[0], got_q[1], got_q[2], got_q[3], got_q[4], got_q[5]} !== 48'h000000_000001) begin
        n_bad++; $display("FAIL rstmid_first_bytes got %h want 000000000001", {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4], got_q[5]});
      end
    end
    n_cmp++; if (got_q.size() != D * NB) begin n_bad++; $display("FAIL rstmid_count got %0d want %0d", got_q.size(), D * NB); end
  endtask

  task automatic test_latency_builds();
    clear_rec();
    aux_start = 1'b1;
    tick();
    aux_start = 1'b0;
    for (int i = 0; i < 20000 && (a1_done < 0 || a3_done < 0); i++) tick();
    tick();
    n_cmp++; if (a1_cnt != D * NB || a1_err != 0) begin n_bad++; $display("FAIL lat1_stream got %0d bytes %0d bad want %0d bytes 0 bad", a1_cnt, a1_err, D * NB); end
    n_cmp++; if (a1_done - a1_rd != D * (1 + 1 + NB)) begin n_bad++; $display("FAIL lat1_cycles got %0d want %0d", a1_done - a1_rd, D * (1 + 1 + NB)); end
    n_cmp++; if (a3_cnt != D * NB || a3_err != 0) begin n_bad++; $display("FAIL lat3_stream got %0d bytes %0d bad want %0d bytes 0 bad", a3_cnt, a3_err, D * NB); end
    n_cmp++; if (a3_done - a3_rd != D * (1 + 3 + NB)) begin n_bad++; $display("FAIL lat3_cycles got %0d want %0d", a3_done - a3_rd, D * (1 + 3 + NB)); end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = 18'(i);
    test_reset();
    test_full_dump();
    test_random_ready();
    test_no_full();
    test_restart_ignored();
    test_reset_mid();
    test_latency_builds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
